// File: rtl/ex_wb_pipe_reg_pkg.sv
// Shared widths and the EX->WB result entry layout for the result pipeline register.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;
    localparam int TAG_W_DEF  = 5;

    typedef struct packed {
        logic                  we;
        logic [REG_AW_DEF-1:0] dst;
        logic [TAG_W_DEF-1:0]  tag;
        logic [DATA_W_DEF-1:0] data;
    } result_t;

endpackage

// File: rtl/ex_wb_pipe_reg_skid_lane.sv
// One result lane: main register M feeding the output, skid register S behind it.
// Optional tag-kill support is compiled in with KILL_EN.
module skid_lane
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
`ifdef KILL_EN
    input  logic              kill_valid,
    input  logic [TAG_W-1:0]  kill_tag,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_we,
    input  logic [REG_AW-1:0] in_dst,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_we,
    output logic [REG_AW-1:0] out_dst,
    output logic [TAG_W-1:0]  out_tag,
    output logic [DATA_W-1:0] out_data
);

    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] dst;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t m_reg;
    entry_t s_reg;
    entry_t in_entry;
    logic   m_valid_reg;
    logic   s_valid_reg;

    logic in_fire;
    logic out_fire;
    logic m_kill;
    logic s_kill;
    logic in_kill;
    logic m_free;
    logic s_live;
    logic in_store;

    assign in_entry = {in_we, in_dst, in_tag, in_data};
    assign in_fire  = in_valid & ~s_valid_reg;
    assign out_fire = m_valid_reg & out_ready;

`ifdef KILL_EN
    assign m_kill  = kill_valid & m_valid_reg & (m_reg.tag == kill_tag);
    assign s_kill  = kill_valid & s_valid_reg & (s_reg.tag == kill_tag);
    assign in_kill = kill_valid & (in_tag == kill_tag);
`else
    assign m_kill  = 1'b0;
    assign s_kill  = 1'b0;
    assign in_kill = 1'b0;
`endif

    // M can take a new entry this edge if it is empty, being consumed, or being killed.
    assign m_free   = ~m_valid_reg | out_fire | m_kill;
    assign s_live   = s_valid_reg & ~s_kill;
    assign in_store = in_fire & ~in_kill;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_reg <= 1'b0;
            s_valid_reg <= 1'b0;
            m_reg       <= '0;
            s_reg       <= '0;
        end else if (flush) begin
            m_valid_reg <= 1'b0;
            s_valid_reg <= 1'b0;
        end else if (s_live && m_free) begin
            m_reg       <= s_reg;
            m_valid_reg <= 1'b1;
            s_valid_reg <= 1'b0;
        end else if (in_store && m_free) begin
            m_reg       <= in_entry;
            m_valid_reg <= 1'b1;
            s_valid_reg <= 1'b0;
        end else if (in_store) begin
            s_reg       <= in_entry;
            s_valid_reg <= 1'b1;
        end else begin
            if (m_free) begin
                m_valid_reg <= 1'b0;
            end
            s_valid_reg <= s_live;
        end
    end

    // in_ready comes straight from the skid flag, so out_ready never reaches it combinationally.
    assign in_ready  = ~s_valid_reg;
    assign out_valid = m_valid_reg;
    assign out_we    = m_reg.we;
    assign out_dst   = m_reg.dst;
    assign out_tag   = m_reg.tag;
    assign out_data  = m_reg.data;

endmodule

// File: rtl/ex_wb_pipe_reg.sv
// Multi-lane EX->WB result pipeline register; each lane is an independent skid buffer.
// Define KILL_EN to add kill_valid/kill_tag tag-based squash across all lanes.
module ex_wb_pipe_reg
    import pipe_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
`ifdef KILL_EN
    input  logic                    kill_valid,
    input  logic [TAG_W-1:0]        kill_tag,
`endif
    input  logic [LANES-1:0]        in_valid,
    output logic [LANES-1:0]        in_ready,
    input  logic [LANES-1:0]        in_we,
    input  logic [LANES*REG_AW-1:0] in_dst,
    input  logic [LANES*TAG_W-1:0]  in_tag,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic [LANES-1:0]        out_valid,
    input  logic [LANES-1:0]        out_ready,
    output logic [LANES-1:0]        out_we,
    output logic [LANES*REG_AW-1:0] out_dst,
    output logic [LANES*TAG_W-1:0]  out_tag,
    output logic [LANES*DATA_W-1:0] out_data
);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        skid_lane #(
            .DATA_W (DATA_W),
            .REG_AW (REG_AW),
            .TAG_W  (TAG_W)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
`ifdef KILL_EN
            .kill_valid (kill_valid),
            .kill_tag   (kill_tag),
`endif
            .in_valid   (in_valid[gi]),
            .in_ready   (in_ready[gi]),
            .in_we      (in_we[gi]),
            .in_dst     (in_dst[gi*REG_AW +: REG_AW]),
            .in_tag     (in_tag[gi*TAG_W +: TAG_W]),
            .in_data    (in_data[gi*DATA_W +: DATA_W]),
            .out_valid  (out_valid[gi]),
            .out_ready  (out_ready[gi]),
            .out_we     (out_we[gi]),
            .out_dst    (out_dst[gi*REG_AW +: REG_AW]),
            .out_tag    (out_tag[gi*TAG_W +: TAG_W]),
            .out_data   (out_data[gi*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_ex_wb_pipe_reg.sv
// Bench for ex_wb_pipe_reg: each lane is modelled as a plain 2-deep FIFO, checked every cycle,
// plus directed literal checks and a 4-lane/64-bit instance.
module tb_ex_wb_pipe_reg;

    localparam int L   = 2;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int TW  = 5;
    localparam int EW  = 1 + AW + TW + DW;
    localparam int WL  = 4;
    localparam int WDW = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [L-1:0]    in_valid, in_ready, in_we, out_valid, out_ready, out_we;
    logic [L*AW-1:0] in_dst, out_dst;
    logic [L*TW-1:0] in_tag, out_tag;
    logic [L*DW-1:0] in_data, out_data;
`ifdef KILL_EN
    logic            kill_valid;
    logic [TW-1:0]   kill_tag;
`endif

    logic [WL-1:0]     w_in_valid, w_in_ready, w_in_we, w_out_valid, w_out_ready, w_out_we;
    logic [WL*AW-1:0]  w_in_dst, w_out_dst;
    logic [WL*TW-1:0]  w_in_tag, w_out_tag;
    logic [WL*WDW-1:0] w_in_data, w_out_data;

    int checks_total  = 0;
    int checks_passed = 0;
    bit chk_en = 1'b0;

    logic [EW-1:0] mmem [L][2];
    int            mcnt [L];

    ex_wb_pipe_reg #(.LANES(L), .DATA_W(DW), .REG_AW(AW), .TAG_W(TW)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
`ifdef KILL_EN
        .kill_valid(kill_valid), .kill_tag(kill_tag),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_dst(in_dst),
        .in_tag(in_tag), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_we(out_we), .out_dst(out_dst), .out_tag(out_tag), .out_data(out_data)
    );

    ex_wb_pipe_reg #(.LANES(WL), .DATA_W(WDW), .REG_AW(AW), .TAG_W(TW)) u_dut_w (
        .clk(clk), .rst(rst), .flush(flush),
`ifdef KILL_EN
        .kill_valid(kill_valid), .kill_tag(kill_tag),
`endif
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_we(w_in_we), .in_dst(w_in_dst),
        .in_tag(w_in_tag), .in_data(w_in_data), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_we(w_out_we), .out_dst(w_out_dst), .out_tag(w_out_tag), .out_data(w_out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drive(input int l, input logic v, input logic we, input logic [AW-1:0] dst,
                         input logic [TW-1:0] tag, input logic [DW-1:0] data);
        in_valid[l]          = v;
        in_we[l]             = we;
        in_dst[l*AW +: AW]   = dst;
        in_tag[l*TW +: TW]   = tag;
        in_data[l*DW +: DW]  = data;
    endtask

    // Reference: each lane is a 2-entry FIFO; ready while fewer than two entries are held.
    initial begin
        bit ir;
        for (int l = 0; l < L; l++) begin
            mcnt[l]    = 0;
            mmem[l][0] = '0;
            mmem[l][1] = '0;
        end
        forever begin
            @(posedge clk);
            if (rst || flush) begin
                for (int l = 0; l < L; l++) mcnt[l] = 0;
            end else begin
                for (int l = 0; l < L; l++) begin
                    ir = (mcnt[l] < 2);
                    if (mcnt[l] > 0 && out_ready[l]) begin
                        mmem[l][0] = mmem[l][1];
                        mcnt[l]--;
                    end
                    if (in_valid[l] && ir) begin
                        mmem[l][mcnt[l]] = {in_we[l], in_dst[l*AW +: AW], in_tag[l*TW +: TW],
                                            in_data[l*DW +: DW]};
                        mcnt[l]++;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the FIFO model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int l = 0; l < L; l++) begin
                    chk($sformatf("model_in_ready_l%0d", l), 64'(in_ready[l]), 64'(mcnt[l] < 2));
                    chk($sformatf("model_out_valid_l%0d", l), 64'(out_valid[l]), 64'(mcnt[l] > 0));
                    if (mcnt[l] > 0) begin
                        chk($sformatf("model_entry_l%0d", l),
                            64'({out_we[l], out_dst[l*AW +: AW], out_tag[l*TW +: TW],
                                 out_data[l*DW +: DW]}),
                            64'(mmem[l][0]));
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = '0;
        in_valid = '1; in_we = '1; in_dst = '1; in_tag = '1; in_data = '1;
        w_in_valid = '0; w_in_we = '0; w_in_dst = '0; w_in_tag = '0; w_in_data = '0;
        w_out_ready = '1;
`ifdef KILL_EN
        kill_valid = 1'b0; kill_tag = '0;
`endif
        chk_en = 1'b1;
        cyc(); cyc();
        rst = 1'b0; in_valid = '0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_we", 64'(out_we), 64'd0);
        chk("rst_out_dst_tag", 64'({out_dst, out_tag}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd3);

        // Streaming on lane 0: one-cycle latency, no bubbles.
        out_ready = 2'b11;
        drive(0, 1'b1, 1'b1, 5'd3, 5'd1, 32'hA1); cyc();
        chk("stream_a1", 64'({out_valid[0], out_tag[4:0], out_data[31:0]}), {1'b1, 5'd1, 32'hA1});
        drive(0, 1'b1, 1'b1, 5'd3, 5'd2, 32'hA2); cyc();
        chk("stream_a2", 64'({out_valid[0], out_tag[4:0], out_data[31:0]}), {1'b1, 5'd2, 32'hA2});
        drive(0, 1'b1, 1'b1, 5'd3, 5'd3, 32'hA3); cyc();
        chk("stream_a3", 64'({out_valid[0], out_tag[4:0], out_data[31:0]}), {1'b1, 5'd3, 32'hA3});
        drive(0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0); cyc();
        chk("stream_drain", 64'(out_valid[0]), 64'd0);

        // Back-pressure on lane 1 while lane 0 keeps streaming.
        out_ready = 2'b01;
        drive(0, 1'b1, 1'($urandom), AW'($urandom), TW'($urandom), $urandom);
        drive(1, 1'b1, 1'b0, 5'd6, 5'd4, 32'h10); cyc();
        chk("bp_ready_after_1", 64'(in_ready[1]), 64'd1);
        chk("bp_out_10", 64'({out_valid[1], out_data[63:32]}), {1'b1, 32'h10});
        drive(0, 1'b1, 1'($urandom), AW'($urandom), TW'($urandom), $urandom);
        drive(1, 1'b1, 1'b0, 5'd7, 5'd5, 32'h20); cyc();
        chk("bp_ready_after_2", 64'(in_ready[1]), 64'd0);
        chk("bp_hold_10", 64'(out_data[63:32]), 64'h10);
        drive(0, 1'b1, 1'($urandom), AW'($urandom), TW'($urandom), $urandom);
        drive(1, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0); cyc();
        chk("bp_stable_10", 64'({out_valid[1], out_data[63:32]}), {1'b1, 32'h10});
        chk("bp_lane0_ready", 64'(in_ready[0]), 64'd1);
        out_ready = 2'b11; cyc();
        chk("bp_out_20", 64'({out_valid[1], out_data[63:32]}), {1'b1, 32'h20});
        chk("bp_ready_back", 64'(in_ready[1]), 64'd1);
        drive(0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0); cyc();
        chk("bp_empty", 64'(out_valid[1]), 64'd0);
        cyc();

        // Fill both lanes, then flush with inputs still asserted.
        out_ready = 2'b00;
        for (int k = 0; k < 2; k++) begin
            for (int l = 0; l < L; l++) drive(l, 1'b1, 1'b1, AW'(k), TW'(10 + k), $urandom);
            cyc();
        end
        chk("full_in_ready", 64'(in_ready), 64'd0);
        flush = 1'b1; in_valid = '1; cyc();
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd3);
        flush = 1'b0; in_valid = '0; out_ready = 2'b11;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("flush_no_residue", 64'(out_valid), 64'd0);
        end

        // Randomised traffic with occasional flushes.
        for (int c = 0; c < 400; c++) begin
            for (int l = 0; l < L; l++)
                drive(l, 1'($urandom), 1'($urandom), AW'($urandom), TW'($urandom), $urandom);
            out_ready = L'($urandom);
            flush = ($urandom_range(0, 31) == 0);
            cyc();
        end
        flush = 1'b0; in_valid = '0; out_ready = '1;
        cyc(); cyc(); cyc();
        chk("quiesce_out_valid", 64'(out_valid), 64'd0);

        // Wide instance: 64-bit data through lane 3.
        w_in_valid[3] = 1'b1; w_in_we[3] = 1'b1; w_in_dst[3*AW +: AW] = 5'd31;
        w_in_tag[3*TW +: TW] = 5'd17; w_in_data[3*WDW +: WDW] = 64'hDEADBEEF_CAFEF00D;
        cyc();
        chk("wide_valid", 64'(w_out_valid), 64'h8);
        chk("wide_data", w_out_data[3*WDW +: WDW], 64'hDEADBEEF_CAFEF00D);
        chk("wide_we_dst_tag", 64'({w_out_we[3], w_out_dst[3*AW +: AW], w_out_tag[3*TW +: TW]}),
            64'({1'b1, 5'd31, 5'd17}));
        w_in_valid = '0; cyc();
        chk("wide_drain", 64'(w_out_valid), 64'd0);

`ifdef KILL_EN
        // Kill the head entry of lane 0; its skid entry must move forward.
        chk_en = 1'b0;
        flush = 1'b1; cyc(); flush = 1'b0;
        out_ready = 2'b00;
        drive(0, 1'b1, 1'b1, 5'd1, 5'd7, 32'h77); cyc();
        drive(0, 1'b1, 1'b1, 5'd2, 5'd9, 32'h99); cyc();
        drive(0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0);
        chk("kill_pre_ready", 64'(in_ready[0]), 64'd0);
        kill_valid = 1'b1; kill_tag = 5'd7; cyc();
        kill_valid = 1'b0;
        chk("kill_out_tag", 64'(out_tag[4:0]), 64'd9);
        chk("kill_out_valid", 64'(out_valid[0]), 64'd1);
        chk("kill_in_ready", 64'(in_ready[0]), 64'd1);
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
